// File: rtl/mem_pkg.sv
// Shared constants and types for the 1024 x 8 scratch RAM.
// Reset state of the RAM is defined by a per-word valid map rather than by clearing storage.
package mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_array.sv
// Plain storage array: clocked write, combinational read of the addressed word.
// No reset on purpose so the array maps onto inferred RAM; the top level masks stale contents.
module mem_array #(
    parameter int ADDR_W = mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];

endmodule

// File: rtl/mem.sv
// Single-port synchronous RAM with chip select, write enable and registered read data.
// A valid bit per word makes every word read as zero after reset until it is written.
module mem
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              write_en;
    logic              read_en;
    logic [DATA_W-1:0] array_rdata;
    logic [DATA_W-1:0] masked_rdata;
    logic [DEPTH-1:0]  valid;

    assign write_en = cs && wr;
    assign read_en  = cs && !wr;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (write_en),
        .addr  (addr),
        .wdata (data_in),
        .rdata (array_rdata)
    );

    // Valid map is the only thing reset touches; array contents survive but are hidden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (write_en) begin
            valid[addr] <= 1'b1;
        end
    end

    assign masked_rdata = valid[addr] ? array_rdata : '0;

    // Output only moves on reads, so writes and idle cycles hold the last read value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (read_en) begin
            data_out <= masked_rdata;
        end
    end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: vector table, directed corner sequences and
// randomized traffic compared against an array-based reference model.
module tb_mem;
    import mem_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int DW    = DEF_DATA_W;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_valid [DEPTH];
    logic [DW-1:0] ref_out;

    typedef struct {
        logic cs;
        logic wr;
        int   addr;
        int   din;
        int   exp_out;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    mem #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Reference model: written words become visible, unwritten ones read zero.
    task automatic modelReset();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        ref_out = '0;
    endtask

    task automatic modelStep(input logic c, input logic w, input int a, input int d);
        if (c && w) begin
            ref_mem[a]   = d[DW-1:0];
            ref_valid[a] = 1'b1;
        end else if (c) begin
            ref_out = ref_valid[a] ? ref_mem[a] : '0;
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w, input int a, input int d);
        @(negedge clk);
        cs      = c;
        wr      = w;
        addr    = a[AW-1:0];
        data_in = d[DW-1:0];
        @(posedge clk);
        modelStep(c, w, a, d);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] exp_val);
        checks++;
        if (data_out !== exp_val) begin
            errors++;
            $display("[TB] FAIL %s: data_out=0x%02h expected 0x%02h", name, data_out, exp_val);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a;
        int exp_i;

        vecs[0]  = '{1'b1, 1'b0,    5, 8'h00, 8'h0A};
        vecs[1]  = '{1'b1, 1'b0,   15, 8'h00, 8'h1E};
        vecs[2]  = '{1'b1, 1'b0,    0, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 1'b0,  700, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 1023, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 1'b0,    5, 8'h00, 8'h0A};
        vecs[6]  = '{1'b0, 1'b1,    3, 8'hFF, 8'h0A};
        vecs[7]  = '{1'b0, 1'b0,    9, 8'h00, 8'h0A};
        vecs[8]  = '{1'b1, 1'b0,    3, 8'h00, 8'h06};
        vecs[9]  = '{1'b1, 1'b1,  512, 8'hA5, 8'h06};
        vecs[10] = '{1'b1, 1'b0,  512, 8'h00, 8'hA5};
        vecs[11] = '{1'b1, 1'b0,   15, 8'h00, 8'h1E};

        rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        modelReset();
        #1;
        checkOutput("reset_state", 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill addresses 0..15 with 2k, idle cycle between writes.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1, k, (2 * k) % 256);
            checkOutput($sformatf("fill_no_writethrough_%0d", k), ref_out);
            applyStimulus(1'b0, 1'b0, k, 0);
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].din);
            checkOutput($sformatf("vector_%0d", i), vecs[i].exp_out[DW-1:0]);
        end

        // Random reads: filled words return 2*addr, 512 holds 0xA5, the rest are zero.
        for (int i = 0; i < 10; i++) begin
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(0, DEPTH - 1);
            exp_i = (a <= 15) ? 2 * a : ((a == 512) ? 8'hA5 : 0);
            applyStimulus(1'b1, 1'b0, a, 0);
            checkOutput($sformatf("random_read_%0d", a), exp_i[DW-1:0]);
        end

        // Asynchronous reset between clock edges.
        applyStimulus(1'b1, 1'b0, 15, 0);
        checkOutput("pre_reset_read15", 8'h1E);
        @(negedge clk);
        cs  = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_immediate", 8'h00);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset_held", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 15, 0);
        checkOutput("post_reset_read15", 8'h00);
        applyStimulus(1'b1, 1'b1, 15, 8'h3C);
        applyStimulus(1'b1, 1'b0, 15, 0);
        checkOutput("rewrite_read15", 8'h3C);

        // Address extremes with neighbours checked for aliasing.
        applyStimulus(1'b1, 1'b1, 0, 8'h11);
        applyStimulus(1'b1, 1'b1, 1023, 8'h22);
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("extreme_addr0", 8'h11);
        applyStimulus(1'b1, 1'b0, 1023, 0);
        checkOutput("extreme_addr1023", 8'h22);
        applyStimulus(1'b1, 1'b0, 1, 0);
        checkOutput("no_alias_addr1", 8'h00);
        applyStimulus(1'b1, 1'b0, 1022, 0);
        checkOutput("no_alias_addr1022", 8'h00);

        // Mixed random traffic, addresses biased to a small pool to get reuse.
        for (int i = 0; i < 300; i++) begin
            logic c;
            logic w;
            c = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1)
                                            : (($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                                                           : $urandom_range(DEPTH - 8, DEPTH - 1));
            applyStimulus(c, w, a, $urandom_range(0, 255));
            checkOutput($sformatf("random_op_%0d", i), ref_out);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
